// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage and ecall/mret trap sequencer.
// Single hart, M-mode only, direct-mode trap vector.
// Optional feature macro: CSR_MCYCLE_EN adds a free-running mcycle counter
// at 0xB00; without it 0xB00 is unimplemented.
module csr_regfile #(
  parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000,
  parameter logic [63:0] HART_ID   = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_w_i,
  input  logic [11:0] csr_a_i,
  input  logic [63:0] csr_d_i,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic [63:0] pc_i,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic        illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  // True when the address names a CSR that accepts writes in this build.
  function automatic logic addr_writable(input logic [11:0] a);
    logic ok;
    case (a)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE: ok = 1'b1;
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Value a write of d to address a would read back (WARL masking applied).
  // Read-only mhartid reads back its constant; unimplemented addresses read 0.
  function automatic logic [63:0] legal_wdata(input logic [11:0] a, input logic [63:0] d);
    logic [63:0] v;
    case (a)
      ADDR_MSTATUS:  v = {51'd0, 2'b11, 3'd0, d[7], 3'd0, d[3], 3'd0};
      ADDR_MTVEC:    v = {d[63:2], 2'b00};
      ADDR_MEPC:     v = {d[63:2], 2'b00};
      ADDR_MCAUSE:   v = d;
      ADDR_MSCRATCH: v = d;
      ADDR_MHARTID:  v = HART_ID;
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:   v = d;
`endif
      default:       v = 64'd0;
    endcase
    return v;
  endfunction

  logic        mie_q,  mie_d;
  logic        mpie_q, mpie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mscratch_q, mscratch_d;
`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_q, mcycle_d;
`endif
  logic [1:0]  state_q, state_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        illegal_q, illegal_d;

  logic [63:0] mstatus_rd_s;
  logic [63:0] rdata_s;
  logic        wr_en_s;
  logic [63:0] wdata_s;

  assign mstatus_rd_s = {51'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  // Combinational read mux with same-cycle write bypass.
  always_comb begin
    rdata_s = 64'd0;
    if (csr_w_i && (csr_a_i == csr_raddr_i)) begin
      rdata_s = legal_wdata(csr_a_i, csr_d_i);
    end else begin
      case (csr_raddr_i)
        ADDR_MSTATUS:  rdata_s = mstatus_rd_s;
        ADDR_MTVEC:    rdata_s = mtvec_q;
        ADDR_MEPC:     rdata_s = mepc_q;
        ADDR_MCAUSE:   rdata_s = mcause_q;
        ADDR_MSCRATCH: rdata_s = mscratch_q;
        ADDR_MHARTID:  rdata_s = HART_ID;
`ifdef CSR_MCYCLE_EN
        ADDR_MCYCLE:   rdata_s = mcycle_q;
`endif
        default:       rdata_s = 64'd0;
      endcase
    end
  end

  assign csr_rdata_o = rdata_s;

  // Next-state: trap entry beats trap return beats a CSR write; a write that
  // collides with a trap event is silently dropped.
  always_comb begin
    wr_en_s       = csr_w_i & ~ecall_i & ~mret_i;
    wdata_s       = legal_wdata(csr_a_i, csr_d_i);
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
`ifdef CSR_MCYCLE_EN
    mcycle_d      = mcycle_q + 64'd1;
`endif
    state_d       = ST_RUN;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = 1'b0;
    if (ecall_i) begin
      mepc_d        = {pc_i[63:2], 2'b00};
      mcause_d      = CAUSE_ECALL_M;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      state_d       = ST_ENTER;
      redirect_pc_d = mtvec_q;
    end else if (mret_i) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      state_d       = ST_RETURN;
      redirect_pc_d = mepc_q;
    end else if (wr_en_s) begin
      illegal_d = ~addr_writable(csr_a_i);
      case (csr_a_i)
        ADDR_MSTATUS: begin
          mie_d  = csr_d_i[3];
          mpie_d = csr_d_i[7];
        end
        ADDR_MTVEC:    mtvec_d    = wdata_s;
        ADDR_MEPC:     mepc_d     = wdata_s;
        ADDR_MCAUSE:   mcause_d   = wdata_s;
        ADDR_MSCRATCH: mscratch_d = wdata_s;
`ifdef CSR_MCYCLE_EN
        ADDR_MCYCLE:   mcycle_d   = wdata_s;
`endif
        default: begin
        end
      endcase
    end else begin
      illegal_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset also cancels a pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RST;
      mepc_q        <= 64'd0;
      mcause_q      <= 64'd0;
      mscratch_q    <= 64'd0;
`ifdef CSR_MCYCLE_EN
      mcycle_q      <= 64'd0;
`endif
      state_q       <= ST_RUN;
      redirect_pc_q <= 64'd0;
      illegal_q     <= 1'b0;
    end else begin
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
`ifdef CSR_MCYCLE_EN
      mcycle_q      <= mcycle_d;
`endif
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  // ENTER and RETURN each last one cycle, so being in either is the redirect strobe.
  assign redirect_o    = (state_q != ST_RUN);
  assign redirect_pc_o = redirect_pc_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Table-driven bench for csr_regfile plus hand sequences for reset-in-ENTER
// and the mcycle (CSR_MCYCLE_EN) behaviour.
module tb_csr_regfile;

  logic        clk;
  logic        rst;
  logic        csr_w_i;
  logic [11:0] csr_a_i;
  logic [63:0] csr_d_i;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        ecall_i;
  logic        mret_i;
  logic [63:0] pc_i;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic        illegal_o;

  int n_vec;
  int n_bad;

  csr_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .csr_w_i       (csr_w_i),
    .csr_a_i       (csr_a_i),
    .csr_d_i       (csr_d_i),
    .csr_raddr_i   (csr_raddr_i),
    .csr_rdata_o   (csr_rdata_o),
    .ecall_i       (ecall_i),
    .mret_i        (mret_i),
    .pc_i          (pc_i),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .illegal_o     (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied for one cycle; exp_rd is the same-cycle read value,
  // exp_rdr/exp_rpc/exp_ill are the registered outputs left by the previous row.
  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [63:0] d;
    logic [11:0] ra;
    logic        ec;
    logic        mr;
    logic [63:0] pc;
    logic [63:0] exp_rd;
    logic        exp_rdr;
    logic [63:0] exp_rpc;
    logic        exp_ill;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic w, input logic [11:0] a, input logic [63:0] d,
                      input logic [11:0] ra, input logic ec, input logic mr,
                      input logic [63:0] pc, input logic [63:0] exp_rd,
                      input logic exp_rdr, input logic [63:0] exp_rpc,
                      input logic exp_ill);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ra = ra; v.ec = ec; v.mr = mr; v.pc = pc;
    v.exp_rd = exp_rd; v.exp_rdr = exp_rdr; v.exp_rpc = exp_rpc; v.exp_ill = exp_ill;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [11:0] a, input logic [63:0] d,
                       input logic [11:0] ra, input logic ec, input logic mr,
                       input logic [63:0] pc);
    csr_w_i = w; csr_a_i = a; csr_d_i = d; csr_raddr_i = ra;
    ecall_i = ec; mret_i = mr; pc_i = pc;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(1'b0, 12'h000, 64'd0, 12'h000, 1'b0, 1'b0, 64'd0);

    //   w     a        d                       ra       ec    mr    pc                      exp_rd                  rdr   rpc                     ill
    addv(1'b0, 12'h000, 64'd0,                  12'h305, 1'b0, 1'b0, 64'd0,                  64'h0000_0000_8000_0000, 1'b0, 64'd0,                  1'b0); // 0
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b0, 64'd0,                  64'h1800,               1'b0, 64'd0,                  1'b0); // 1
    addv(1'b0, 12'h000, 64'd0,                  12'hF14, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'd0,                  1'b0); // 2
    addv(1'b0, 12'h000, 64'd0,                  12'h341, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'd0,                  1'b0); // 3
    addv(1'b0, 12'h000, 64'd0,                  12'h342, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'd0,                  1'b0); // 4
    addv(1'b0, 12'h000, 64'd0,                  12'h340, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'd0,                  1'b0); // 5
    addv(1'b0, 12'h000, 64'd0,                  12'h7C0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'd0,                  1'b0); // 6
    addv(1'b1, 12'h340, 64'hDEAD_BEEF,          12'h340, 1'b0, 1'b0, 64'd0,                  64'hDEAD_BEEF,          1'b0, 64'd0,                  1'b0); // 7 bypass
    addv(1'b0, 12'h000, 64'd0,                  12'h340, 1'b0, 1'b0, 64'd0,                  64'hDEAD_BEEF,          1'b0, 64'd0,                  1'b0); // 8
    addv(1'b1, 12'h305, 64'h1003,               12'h305, 1'b0, 1'b0, 64'd0,                  64'h1000,               1'b0, 64'd0,                  1'b0); // 9
    addv(1'b0, 12'h000, 64'd0,                  12'h305, 1'b0, 1'b0, 64'd0,                  64'h1000,               1'b0, 64'd0,                  1'b0); // 10
    addv(1'b1, 12'h300, 64'h8,                  12'h300, 1'b0, 1'b0, 64'd0,                  64'h1808,               1'b0, 64'd0,                  1'b0); // 11 MIE=1
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b1, 1'b0, 64'h0000_0000_8000_0100, 64'h1808,              1'b0, 64'd0,                  1'b0); // 12 ecall
    addv(1'b0, 12'h000, 64'd0,                  12'h341, 1'b0, 1'b0, 64'd0,                  64'h0000_0000_8000_0100, 1'b1, 64'h1000,              1'b0); // 13
    addv(1'b0, 12'h000, 64'd0,                  12'h342, 1'b0, 1'b0, 64'd0,                  64'd11,                 1'b0, 64'h1000,               1'b0); // 14
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b1, 64'd0,                  64'h1880,               1'b0, 64'h1000,               1'b0); // 15 mret
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b0, 64'd0,                  64'h1888,               1'b1, 64'h0000_0000_8000_0100, 1'b0); // 16
    addv(1'b1, 12'h340, 64'h1234,               12'h342, 1'b1, 1'b0, 64'h0000_0000_8000_0200, 64'd11,                1'b0, 64'h0000_0000_8000_0100, 1'b0); // 17 ecall+write
    addv(1'b0, 12'h000, 64'd0,                  12'h340, 1'b0, 1'b0, 64'd0,                  64'hDEAD_BEEF,          1'b1, 64'h1000,               1'b0); // 18
    addv(1'b1, 12'h7C0, 64'h5,                  12'h341, 1'b0, 1'b0, 64'd0,                  64'h0000_0000_8000_0200, 1'b0, 64'h1000,              1'b0); // 19 bad addr
    addv(1'b0, 12'h000, 64'd0,                  12'h7C0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'h1000,               1'b1); // 20
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b0, 64'd0,                  64'h1880,               1'b0, 64'h1000,               1'b0); // 21
    addv(1'b1, 12'hF14, 64'h7,                  12'hF14, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'h1000,               1'b0); // 22 read-only
    addv(1'b0, 12'h000, 64'd0,                  12'hF14, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 64'h1000,               1'b1); // 23
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b1, 64'd0,                  64'h1880,               1'b0, 64'h1000,               1'b0); // 24 mret
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b1, 1'b0, 64'h0000_0000_8000_0303, 64'h1888,              1'b1, 64'h0000_0000_8000_0200, 1'b0); // 25 back-to-back ecall
    addv(1'b0, 12'h000, 64'd0,                  12'h341, 1'b0, 1'b0, 64'd0,                  64'h0000_0000_8000_0300, 1'b1, 64'h1000,              1'b0); // 26
    addv(1'b0, 12'h000, 64'd0,                  12'h300, 1'b0, 1'b0, 64'd0,                  64'h1880,               1'b0, 64'h1000,               1'b0); // 27
    addv(1'b1, 12'h341, 64'h1234_5677,          12'h341, 1'b0, 1'b0, 64'd0,                  64'h1234_5674,          1'b0, 64'h1000,               1'b0); // 28
    addv(1'b1, 12'h342, 64'hFFFF_FFFF_FFFF_FFFF, 12'h300, 1'b0, 1'b0, 64'd0,                 64'h1880,               1'b0, 64'h1000,               1'b0); // 29
    addv(1'b0, 12'h000, 64'd0,                  12'h342, 1'b0, 1'b0, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1000,              1'b0); // 30
    addv(1'b1, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 12'h300, 1'b0, 1'b0, 64'd0,                 64'h1888,               1'b0, 64'h1000,               1'b0); // 31

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].w, vq[i].a, vq[i].d, vq[i].ra, vq[i].ec, vq[i].mr, vq[i].pc);
      #1;
      chk($sformatf("row%0d rdata", i), csr_rdata_o, vq[i].exp_rd);
      chk($sformatf("row%0d redirect", i), {63'd0, redirect_o}, {63'd0, vq[i].exp_rdr});
      chk($sformatf("row%0d redirect_pc", i), redirect_pc_o, vq[i].exp_rpc);
      chk($sformatf("row%0d illegal", i), {63'd0, illegal_o}, {63'd0, vq[i].exp_ill});
      @(negedge clk);
    end

    // Reset asserted while in ENTER cancels the redirect and restores everything.
    drive(1'b0, 12'h000, 64'd0, 12'h000, 1'b1, 1'b0, 64'h4000_0000);
    @(negedge clk);
    drive(1'b0, 12'h000, 64'd0, 12'h000, 1'b0, 1'b0, 64'd0);
    rst = 1'b1;
    #1;
    chk("enter before reset", {63'd0, redirect_o}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    csr_raddr_i = 12'h300;
    #1;
    chk("rst redirect", {63'd0, redirect_o}, 64'd0);
    chk("rst redirect_pc", redirect_pc_o, 64'd0);
    chk("rst illegal", {63'd0, illegal_o}, 64'd0);
    chk("rst mstatus", csr_rdata_o, 64'h1800);
    csr_raddr_i = 12'h305; #1;
    chk("rst mtvec", csr_rdata_o, 64'h0000_0000_8000_0000);
    csr_raddr_i = 12'h341; #1;
    chk("rst mepc", csr_rdata_o, 64'd0);
    csr_raddr_i = 12'h342; #1;
    chk("rst mcause", csr_rdata_o, 64'd0);
    csr_raddr_i = 12'h340; #1;
    chk("rst mscratch", csr_rdata_o, 64'd0);
    @(negedge clk);

`ifdef CSR_MCYCLE_EN
    // mcycle load of all-ones, then wrap to 0 and count on.
    drive(1'b1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 12'hB00, 1'b0, 1'b0, 64'd0);
    #1;
    chk("mcycle bypass", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    drive(1'b0, 12'h000, 64'd0, 12'hB00, 1'b0, 1'b0, 64'd0);
    #1;
    chk("mcycle loaded", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mcycle illegal", {63'd0, illegal_o}, 64'd0);
    @(negedge clk); #1;
    chk("mcycle wrap", csr_rdata_o, 64'd0);
    @(negedge clk); #1;
    chk("mcycle inc", csr_rdata_o, 64'd1);
`else
    // Without the counter, 0xB00 is unimplemented.
    drive(1'b1, 12'hB00, 64'h5, 12'hB00, 1'b0, 1'b0, 64'd0);
    #1;
    chk("mcycle absent bypass", csr_rdata_o, 64'd0);
    @(negedge clk);
    drive(1'b0, 12'h000, 64'd0, 12'hB00, 1'b0, 1'b0, 64'd0);
    #1;
    chk("mcycle absent illegal", {63'd0, illegal_o}, 64'd1);
    chk("mcycle absent read", csr_rdata_o, 64'd0);
    @(negedge clk); #1;
    chk("illegal one cycle", {63'd0, illegal_o}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
